ycbcr_rgb_csc: RTL and testbench

YCBCR_RGB_CSC -- requirements
Module: ycbcr_rgb_csc

---
 rtl/ycbcr_rgb_csc_if.sv | 37 +++
 rtl/ycbcr_rgb_csc.sv | 145 ++++++++++++++
 tb/tb_ycbcr_rgb_csc.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr_rgb_csc_if.sv
`default_nettype none
// ==========================================================================
// ycbcr_rgb_csc_if : pixel-in / pixel-out bundle with valid/ready handshakes
// Revision 1.0
// ==========================================================================
interface ycbcr_rgb_csc_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_y;
  logic [DATA_W-1:0] i_cb;
  logic [DATA_W-1:0] i_cr;
  logic              i_h_sync;
  logic              i_v_sync;
  logic              i_data_en;
  logic [1:0]        i_mode;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_r;
  logic [DATA_W-1:0] o_g;
  logic [DATA_W-1:0] o_b;
  logic              o_h_sync;
  logic              o_v_sync;
  logic              o_data_en;
  logic              o_valid;
  logic              i_ready;

  modport slave (
    input  i_y, i_cb, i_cr, i_h_sync, i_v_sync, i_data_en, i_mode, i_valid, i_ready,
    output o_ready, o_r, o_g, o_b, o_h_sync, o_v_sync, o_data_en, o_valid
  );

  modport master (
    output i_y, i_cb, i_cr, i_h_sync, i_v_sync, i_data_en, i_mode, i_valid, i_ready,
    input  o_ready, o_r, o_g, o_b, o_h_sync, o_v_sync, o_data_en, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/ycbcr_rgb_csc.sv
`default_nettype none
// ==========================================================================
// ycbcr_rgb_csc : 4-stage YCbCr -> RGB converter, globally stalled pipeline.
// Optional macro YCBCR_RGB_ROUND_EN selects round-half-up over truncation.
// Revision 1.0
// ==========================================================================
module ycbcr_rgb_csc #(
  parameter int DATA_W    = 8,
  parameter int COEF_FRAC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ycbcr_rgb_csc_if.slave bus
);
  localparam int SW = DATA_W + 14;
  localparam logic [DATA_W-1:0]    c_Y_OFF = DATA_W'(16 << (DATA_W - 8));
  localparam logic [DATA_W-1:0]    c_C_OFF = DATA_W'(128 << (DATA_W - 8));
  localparam logic signed [SW-1:0] c_MAX   = SW'((1 << DATA_W) - 1);
`ifdef YCBCR_RGB_ROUND_EN
  localparam logic signed [SW-1:0] c_RND   = SW'(1 << (COEF_FRAC - 1));
`else
  localparam logic signed [SW-1:0] c_RND   = '0;
`endif

  function automatic logic [DATA_W-1:0] clamp_f(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> COEF_FRAC;
    if (sh[SW-1])       clamp_f = '0;
    else if (sh > c_MAX) clamp_f = '1;
    else                clamp_f = sh[DATA_W-1:0];
  endfunction

  logic              advance_w, accept_w, vs_rise_w;
  logic [1:0]        mode_q, mode_eff_w;
  logic              vs_prev_q;
  logic [DATA_W-1:0] y_off_w;

  // stage 1: latch + offset
  logic                    v1_q;
  logic [1:0]              mode1_q;
  logic signed [DATA_W:0]  yo1_q, cbo1_q, cro1_q, yo_d, cbo_d, cro_d;
  logic [DATA_W-1:0]       y1_q, cb1_q, cr1_q;
  logic [2:0]              sb1_q;
  // stage 2: multiply
  logic                    v2_q, byp2_q;
  logic signed [11:0]      k_y_w, k_rv_w, k_gu_w, k_gv_w, k_bu_w;
  logic signed [SW-1:0]    py2_q, prv2_q, pgu2_q, pgv2_q, pbu2_q;
  logic signed [SW-1:0]    py_d, prv_d, pgu_d, pgv_d, pbu_d;
  logic [DATA_W-1:0]       y2_q, cb2_q, cr2_q;
  logic [2:0]              sb2_q;
  // stage 3: sum
  logic                    v3_q, byp3_q;
  logic signed [SW-1:0]    sr3_q, sg3_q, sb3s_q, sr_d, sg_d, sbs_d;
  logic [DATA_W-1:0]       y3_q, cb3_q, cr3_q;
  logic [2:0]              sb3_q;
  // stage 4: round/clamp, drives the outputs
  logic                    o_valid_q;
  logic [DATA_W-1:0]       o_r_q, o_g_q, o_b_q, o_r_d, o_g_d, o_b_d;
  logic [2:0]              sbo_q;

  assign advance_w  = !o_valid_q || bus.i_ready;
  assign accept_w   = bus.i_valid && advance_w;
  assign vs_rise_w  = accept_w && bus.i_v_sync && !vs_prev_q;
  // the v_sync-rising beat itself already uses the newly requested mode
  assign mode_eff_w = vs_rise_w ? bus.i_mode : mode_q;
  assign y_off_w    = (mode_eff_w == 2'd2) ? '0 : c_Y_OFF;

  assign yo_d  = $signed({1'b0, bus.i_y})  - $signed({1'b0, y_off_w});
  assign cbo_d = $signed({1'b0, bus.i_cb}) - $signed({1'b0, c_C_OFF});
  assign cro_d = $signed({1'b0, bus.i_cr}) - $signed({1'b0, c_C_OFF});

  always_comb begin
    k_y_w  = '0;
    k_rv_w = '0;
    k_gu_w = '0;
    k_gv_w = '0;
    k_bu_w = '0;
    case (mode1_q)
      2'd0: begin k_y_w = 12'sd298; k_rv_w = 12'sd409; k_gu_w = 12'sd100; k_gv_w = 12'sd208; k_bu_w = 12'sd516; end
      2'd1: begin k_y_w = 12'sd298; k_rv_w = 12'sd459; k_gu_w = 12'sd55;  k_gv_w = 12'sd136; k_bu_w = 12'sd541; end
      2'd2: begin k_y_w = 12'sd256; k_rv_w = 12'sd359; k_gu_w = 12'sd88;  k_gv_w = 12'sd183; k_bu_w = 12'sd454; end
      default: ;
    endcase
  end

  assign py_d  = SW'(yo1_q)  * SW'(k_y_w);
  assign prv_d = SW'(cro1_q) * SW'(k_rv_w);
  assign pgu_d = SW'(cbo1_q) * SW'(k_gu_w);
  assign pgv_d = SW'(cro1_q) * SW'(k_gv_w);
  assign pbu_d = SW'(cbo1_q) * SW'(k_bu_w);

  assign sr_d  = py2_q + prv2_q + c_RND;
  assign sg_d  = py2_q - pgu2_q - pgv2_q + c_RND;
  assign sbs_d = py2_q + pbu2_q + c_RND;

  assign o_r_d = byp3_q ? cr3_q : clamp_f(sr3_q);
  assign o_g_d = byp3_q ? y3_q  : clamp_f(sg3_q);
  assign o_b_d = byp3_q ? cb3_q : clamp_f(sb3s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'd0;
      vs_prev_q <= 1'b0;
      v1_q <= 1'b0; mode1_q <= 2'd0; yo1_q <= '0; cbo1_q <= '0; cro1_q <= '0;
      y1_q <= '0; cb1_q <= '0; cr1_q <= '0; sb1_q <= '0;
      v2_q <= 1'b0; byp2_q <= 1'b0; py2_q <= '0; prv2_q <= '0; pgu2_q <= '0;
      pgv2_q <= '0; pbu2_q <= '0; y2_q <= '0; cb2_q <= '0; cr2_q <= '0; sb2_q <= '0;
      v3_q <= 1'b0; byp3_q <= 1'b0; sr3_q <= '0; sg3_q <= '0; sb3s_q <= '0;
      y3_q <= '0; cb3_q <= '0; cr3_q <= '0; sb3_q <= '0;
      o_valid_q <= 1'b0; o_r_q <= '0; o_g_q <= '0; o_b_q <= '0; sbo_q <= '0;
    end else begin
      if (accept_w) begin
        vs_prev_q <= bus.i_v_sync;
        if (vs_rise_w) mode_q <= bus.i_mode;
      end
      if (advance_w) begin
        v1_q <= bus.i_valid; mode1_q <= mode_eff_w;
        yo1_q <= yo_d; cbo1_q <= cbo_d; cro1_q <= cro_d;
        y1_q <= bus.i_y; cb1_q <= bus.i_cb; cr1_q <= bus.i_cr;
        sb1_q <= {bus.i_h_sync, bus.i_v_sync, bus.i_data_en};

        v2_q <= v1_q; byp2_q <= (mode1_q == 2'd3);
        py2_q <= py_d; prv2_q <= prv_d; pgu2_q <= pgu_d; pgv2_q <= pgv_d; pbu2_q <= pbu_d;
        y2_q <= y1_q; cb2_q <= cb1_q; cr2_q <= cr1_q; sb2_q <= sb1_q;

        v3_q <= v2_q; byp3_q <= byp2_q;
        sr3_q <= sr_d; sg3_q <= sg_d; sb3s_q <= sbs_d;
        y3_q <= y2_q; cb3_q <= cb2_q; cr3_q <= cr2_q; sb3_q <= sb2_q;

        o_valid_q <= v3_q;
        o_r_q <= o_r_d; o_g_q <= o_g_d; o_b_q <= o_b_d; sbo_q <= sb3_q;
      end
    end
  end

  assign bus.o_ready   = advance_w;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_r       = o_r_q;
  assign bus.o_g       = o_g_q;
  assign bus.o_b       = o_b_q;
  assign bus.o_h_sync  = sbo_q[2];
  assign bus.o_v_sync  = sbo_q[1];
  assign bus.o_data_en = sbo_q[0];
endmodule
`default_nettype wire

// File: tb/tb_ycbcr_rgb_csc.sv
`default_nettype none
// ==========================================================================
// tb_ycbcr_rgb_csc : directed, self-checking bench for ycbcr_rgb_csc (DATA_W=8)
// Revision 1.0
// ==========================================================================
module tb_ycbcr_rgb_csc;
  localparam int DATA_W = 8;
`ifdef YCBCR_RGB_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  // 298*219 = 65262 and 298*65+409*112 = 65178: both 254.x before rounding
  localparam logic [7:0] E_WHITE = RND ? 8'd255 : 8'd254;
  // 65262 - 208*112 = 41966 -> 163.93
  localparam logic [7:0] E_G601  = RND ? 8'd164 : 8'd163;
  // 25600 - 359*68 = 1188 -> 4.64
  localparam logic [7:0] E_RFULL = RND ? 8'd5 : 8'd4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  ycbcr_rgb_csc_if #(.DATA_W(DATA_W)) bus ();

  ycbcr_rgb_csc #(.DATA_W(DATA_W), .COEF_FRAC(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic set_beat(input logic [7:0] y, cb, cr, input logic [1:0] m,
                          input logic hs, vs, de);
    bus.i_y = y; bus.i_cb = cb; bus.i_cr = cr; bus.i_mode = m;
    bus.i_h_sync = hs; bus.i_v_sync = vs; bus.i_data_en = de;
    bus.i_valid = 1'b1;
  endtask

  task automatic drive_beat(input logic [7:0] y, cb, cr, input logic [1:0] m,
                            input logic hs, vs, de);
    set_beat(y, cb, cr, m, hs, vs, de);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  // negedges waited after the accepting edge until o_valid (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // v_sync rising beat loads the mode; both beats are drained afterwards
  task automatic select_mode(input logic [1:0] m);
    drive_beat(8'd0, 8'd128, 8'd128, m, 1'b0, 1'b0, 1'b0);
    drive_beat(8'd0, 8'd128, 8'd128, m, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_y = '0; bus.i_cb = '0; bus.i_cr = '0; bus.i_mode = 2'd0;
    bus.i_h_sync = 1'b0; bus.i_v_sync = 1'b0; bus.i_data_en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_valid: got %b expected 0", bus.o_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready);
    end
    n_checks++;
    if ({bus.o_valid, bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en} !== 28'h0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b rgb=%h %h %h sb=%b%b%b expected all 0",
                         bus.o_valid, bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en);
    end
    @(negedge clk);
  endtask

  task automatic test_mode0;
    logic [7:0] vy[4], vcb[4], vcr[4], er[4], eg[4], eb[4];
    int n;
    vy  = '{8'd16,  8'd235,  8'd81,  8'd235};
    vcb = '{8'd128, 8'd128,  8'd90,  8'd128};
    vcr = '{8'd128, 8'd128,  8'd240, 8'd240};
    er  = '{8'd0,   E_WHITE, E_WHITE, 8'd255};
    // G for (81,90,240) is 19370+3800-23296 = -126, clamped to 0
    eg  = '{8'd0,   E_WHITE, 8'd0,   E_G601};
    eb  = '{8'd0,   E_WHITE, 8'd0,   E_WHITE};
    select_mode(2'd0);
    for (int i = 0; i < 4; i++) begin
      drive_beat(vy[i], vcb[i], vcr[i], 2'd0, i[0], 1'b0, 1'b1);
      wait_valid(n);
      n_checks++;
      if (n !== 3) begin
        n_fail++; $display("FAIL mode0_latency[%0d]: got %0d expected 3", i, n);
      end
      n_checks++;
      if ({bus.o_r, bus.o_g, bus.o_b} !== {er[i], eg[i], eb[i]}) begin
        n_fail++; $display("FAIL mode0_rgb[%0d]: got %0d %0d %0d expected %0d %0d %0d",
                           i, bus.o_r, bus.o_g, bus.o_b, er[i], eg[i], eb[i]);
      end
      n_checks++;
      if ({bus.o_h_sync, bus.o_v_sync, bus.o_data_en} !== {i[0], 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL mode0_sideband[%0d]: got %b%b%b expected %b01",
                           i, bus.o_h_sync, bus.o_v_sync, bus.o_data_en, i[0]);
      end
    end
  endtask

  task automatic test_mode2;
    logic [7:0] vy[3], vcb[3], vcr[3], er[3], eg[3], eb[3];
    int n;
    vy  = '{8'd100, 8'd255, 8'd0};
    vcb = '{8'd150, 8'd128, 8'd128};
    vcr = '{8'd60,  8'd128, 8'd128};
    er  = '{E_RFULL, 8'd255, 8'd0};
    eg  = '{8'd141,  8'd255, 8'd0};
    eb  = '{8'd139,  8'd255, 8'd0};
    select_mode(2'd2);
    for (int i = 0; i < 3; i++) begin
      drive_beat(vy[i], vcb[i], vcr[i], 2'd2, 1'b0, 1'b0, 1'b1);
      wait_valid(n);
      n_checks++;
      if ({bus.o_r, bus.o_g, bus.o_b} !== {er[i], eg[i], eb[i]} || n !== 3) begin
        n_fail++; $display("FAIL mode2_rgb[%0d]: got %0d %0d %0d after %0d expected %0d %0d %0d after 3",
                           i, bus.o_r, bus.o_g, bus.o_b, n, er[i], eg[i], eb[i]);
      end
    end
  endtask

  task automatic test_bypass;
    logic [7:0] vy[2], vcb[2], vcr[2];
    int n;
    vy  = '{8'd10, 8'd255};
    vcb = '{8'd20, 8'd0};
    vcr = '{8'd30, 8'd128};
    select_mode(2'd3);
    for (int i = 0; i < 2; i++) begin
      drive_beat(vy[i], vcb[i], vcr[i], 2'd3, 1'b1, 1'b0, 1'b0);
      wait_valid(n);
      n_checks++;
      if ({bus.o_r, bus.o_g, bus.o_b} !== {vcr[i], vy[i], vcb[i]} || n !== 3) begin
        n_fail++; $display("FAIL bypass_rgb[%0d]: got %0d %0d %0d after %0d expected %0d %0d %0d after 3",
                           i, bus.o_r, bus.o_g, bus.o_b, n, vcr[i], vy[i], vcb[i]);
      end
    end
  endtask

  task automatic test_mode_switch;
    logic [1:0] vm[4];
    logic       vvs[4];
    logic [7:0] eg[4];
    int n;
    vm  = '{2'd1, 2'd1, 2'd0, 2'd0};
    vvs = '{1'b0, 1'b1, 1'b1, 1'b0};
    // BT.709 G: 65262 - 136*112 = 50030 -> 195 either way
    eg  = '{E_G601, 8'd195, 8'd195, 8'd195};
    select_mode(2'd0);
    for (int i = 0; i < 4; i++) begin
      drive_beat(8'd235, 8'd128, 8'd240, vm[i], 1'b0, vvs[i], 1'b1);
      wait_valid(n);
      n_checks++;
      if ({bus.o_r, bus.o_g} !== {8'd255, eg[i]} || n !== 3) begin
        n_fail++; $display("FAIL mode_switch[%0d]: got R=%0d G=%0d after %0d expected R=255 G=%0d after 3",
                           i, bus.o_r, bus.o_g, n, eg[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int got, first, last, k;
    got = 0; first = -1; last = -1;
    select_mode(2'd3);
    for (int t = 0; t < 16; t++) begin
      if (bus.o_valid) begin
        if (first < 0) first = t;
        last = t;
        k = got;
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en} !==
            {8'(10*k+3), 8'(10*k+1), 8'(10*k+2), k[0], (k == 5), (k != 3)}) begin
          n_fail++; $display("FAIL b2b_beat[%0d]: got %0d %0d %0d sb=%b%b%b expected %0d %0d %0d sb=%b%b%b",
                             k, bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en,
                             10*k+3, 10*k+1, 10*k+2, k[0], (k == 5), (k != 3));
        end
        got++;
      end
      if (t < 8) set_beat(8'(10*t+1), 8'(10*t+2), 8'(10*t+3), 2'd3, t[0], (t == 5), (t != 3));
      else       bus.i_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (first !== 4 || last !== 11 || got !== 8) begin
      n_fail++; $display("FAIL b2b_timing: got first=%0d last=%0d count=%0d expected 4 11 8", first, last, got);
    end
  endtask

  task automatic test_stall;
    int sent, got;
    sent = 0; got = 0;
    select_mode(2'd3);
    for (int t = 0; t < 40; t++) begin
      bus.i_ready = (t >= 10);
      #1;
      if (t >= 4 && t < 10) begin
        n_checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en}
            !== {1'b0, 1'b1, 8'd200, 8'd100, 8'd50, 3'b001}) begin
          n_fail++; $display("FAIL stall_frozen[t=%0d]: got rdy=%b v=%b %0d %0d %0d expected rdy=0 v=1 200 100 50",
                             t, bus.o_ready, bus.o_valid, bus.o_r, bus.o_g, bus.o_b);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        n_checks++;
        if ({bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en} !==
            {8'(200+got), 8'(100+got), 8'(50+got), got[0], 1'b0, 1'b1}) begin
          n_fail++; $display("FAIL stall_order[%0d]: got %0d %0d %0d expected %0d %0d %0d",
                             got, bus.o_r, bus.o_g, bus.o_b, 200+got, 100+got, 50+got);
        end
        got++;
      end
      if (bus.o_ready && sent < 10) begin
        set_beat(8'(100+sent), 8'(50+sent), 8'(200+sent), 2'd3, sent[0], 1'b0, 1'b1);
        sent++;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    n_checks++;
    if (got !== 10 || sent !== 10 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_count: got recv=%0d sent=%0d v=%b expected 10 10 0", got, sent, bus.o_valid);
    end
  endtask

  task automatic test_reset_midflight;
    int seen, n;
    for (int t = 0; t < 4; t++) begin
      set_beat(8'(11*t+11), 8'(11*t+22), 8'(11*t+33), 2'd3, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    n_checks++;
    if ({bus.o_valid, bus.o_r} !== {1'b1, 8'd33}) begin
      n_fail++; $display("FAIL midflight_pre: got v=%b R=%0d expected v=1 R=33", bus.o_valid, bus.o_r);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_valid, bus.o_r, bus.o_g, bus.o_b, bus.o_h_sync, bus.o_v_sync, bus.o_data_en} !== 28'h0) begin
      n_fail++; $display("FAIL midflight_clear: got v=%b rgb=%h %h %h expected all 0",
                         bus.o_valid, bus.o_r, bus.o_g, bus.o_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL midflight_ready: got %b expected 1", bus.o_ready);
    end
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.o_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midflight_discard: got %0d stale outputs expected 0", seen);
    end
    // active mode is back to BT.601 limited, so mode 3 here is ignored
    drive_beat(8'd235, 8'd128, 8'd128, 2'd3, 1'b0, 1'b0, 1'b1);
    wait_valid(n);
    n_checks++;
    if ({bus.o_r, bus.o_g, bus.o_b} !== {E_WHITE, E_WHITE, E_WHITE} || n !== 3) begin
      n_fail++; $display("FAIL midflight_after: got %0d %0d %0d after %0d expected %0d x3 after 3",
                         bus.o_r, bus.o_g, bus.o_b, n, E_WHITE);
    end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode2;
    test_bypass;
    test_mode_switch;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
